fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage ARM-subset pipeline.
- Owns the program counter and drives the byte address into the combinational, byte-addressed, big-endian-packed instruction memory.
- Captures the returned word plus PC+4 into the IF/ID pipeline register consumed by decode.
- Handles hazard freeze, branch redirect/flush and fetch accounting.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if_id_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline defines: widths, reset PC, NOP, fetch FSM encoding
package fetch_stage_pkg;

   localparam int unsigned INSTRUCTION_LEN = 32;
   localparam logic [INSTRUCTION_LEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // All-zero word doubles as the bubble written on flush
   localparam logic [INSTRUCTION_LEN-1:0] NOP = '0;

   localparam logic [0:0] BOOT = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   function automatic logic [INSTRUCTION_LEN-1:0] word_align(
      input logic [INSTRUCTION_LEN-1:0] addr
   );
      return {addr[INSTRUCTION_LEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - pipeline register with enable, synchronous flush and async reset
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int unsigned W = INSTRUCTION_LEN
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         flush_i,
   input  logic [W-1:0] pc_i,
   input  logic [W-1:0] instr_i,
   input  logic         valid_i,
   output logic [W-1:0] pc_o,
   output logic [W-1:0] instr_o,
   output logic         valid_o
);

   logic [W-1:0] pc_q,    pc_d;
   logic [W-1:0] instr_q, instr_d;
   logic         valid_q, valid_d;

   // Flush outranks enable so a squash is never lost to a stall
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (flush_i) begin
         pc_d    = '0;
         instr_d = '0;
         valid_d = 1'b0;
      end else if (en_i) begin
         pc_d    = pc_i;
         instr_d = instr_i;
         valid_d = valid_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, branch redirect, freeze, IF/ID capture, fetch counter
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned            INSTR_LEN = INSTRUCTION_LEN,
   parameter logic [INSTR_LEN-1:0]   RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned            PC_STEP   = 4,
   parameter int unsigned            CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 branch_taken,
   input  logic [INSTR_LEN-1:0] branch_addr,
   output logic [INSTR_LEN-1:0] imem_addr,
   input  logic [INSTR_LEN-1:0] imem_rdata,
   output logic [INSTR_LEN-1:0] if_id_pc,
   output logic [INSTR_LEN-1:0] if_id_instr,
   output logic                 if_id_valid,
   output logic [CNT_W-1:0]     fetch_count
);

   logic [0:0]           state_q, state_d;
   logic [INSTR_LEN-1:0] pc_q, pc_d;
   logic [INSTR_LEN-1:0] pc_plus;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 redirect, hold, boot_squash, capture, flush;

   assign pc_plus = pc_q + INSTR_LEN'(PC_STEP);

   // In BOOT the controls only decide between squash and capture; an X there
   // falls through to the capture path instead of reaching the PC
   always_comb begin
      redirect    = 1'b0;
      hold        = 1'b0;
      boot_squash = 1'b0;
      capture     = 1'b0;
      if (state_q == BOOT) begin
         if (freeze || branch_taken) boot_squash = 1'b1;
         else                        capture     = 1'b1;
      end else begin
         if (branch_taken)           redirect    = 1'b1;
         else if (freeze)            hold        = 1'b1;
         else                        capture     = 1'b1;
      end
   end

   assign flush = redirect | boot_squash;

   always_comb begin
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      state_d = RUN;
      if (redirect) begin
         pc_d = word_align(branch_addr);
      end else if (capture) begin
         pc_d  = pc_plus;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   if_id_reg #(
      .W (INSTR_LEN)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .en_i    (capture),
      .flush_i (flush),
      .pc_i    (pc_plus),
      .instr_i (imem_rdata),
      .valid_i (1'b1),
      .pc_o    (if_id_pc),
      .instr_o (if_id_instr),
      .valid_o (if_id_valid)
   );

   assign imem_addr   = pc_q;
   assign fetch_count = cnt_q;

   logic unused_hold;
   assign unused_hold = hold;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          freeze;
   logic          branch_taken;
   logic [31:0]   branch_addr;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic [31:0]   if_id_pc;
   logic [31:0]   if_id_instr;
   logic          if_id_valid;
   logic [CW-1:0] fetch_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hE3A0_0000 + a;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_stage #(.CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .if_id_valid  (if_id_valid),
      .fetch_count  (fetch_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp %h", imem_addr, 32'h0); end
      tests++; if ({if_id_pc, if_id_instr, if_id_valid} !== 65'h0) begin fails++; $display("FAIL rst_ifid got %h %h %b exp 0", if_id_pc, if_id_instr, if_id_valid); end
      tests++; if (fetch_count !== 0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", fetch_count); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 5; i++) begin
         tests++; if (imem_addr !== 32'(4*i)) begin fails++; $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, 32'(4*i)); end
         step();
         tests++; if (if_id_pc !== 32'(4*(i+1)) || if_id_instr !== mem_word(32'(4*i)) || if_id_valid !== 1'b1)
            begin fails++; $display("FAIL seq_ifid%0d got %h %h %b exp %h %h 1", i, if_id_pc, if_id_instr, if_id_valid, 32'(4*(i+1)), mem_word(32'(4*i))); end
      end
      tests++; if (fetch_count !== 5) begin fails++; $display("FAIL seq_cnt got %0d exp 5", fetch_count); end
   endtask

   task automatic test_freeze();
      do_reset();
      step(); step();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (imem_addr !== 32'h8 || if_id_pc !== 32'h8 || if_id_instr !== mem_word(32'h4) || fetch_count !== 2)
            begin fails++; $display("FAIL frz_hold%0d got %h %h %h %0d exp 8 8 %h 2", i, imem_addr, if_id_pc, if_id_instr, fetch_count, mem_word(32'h4)); end
      end
      freeze = 1'b0;
      step();
      tests++; if (if_id_pc !== 32'hC || if_id_instr !== mem_word(32'h8) || fetch_count !== 3 || imem_addr !== 32'hC)
         begin fails++; $display("FAIL frz_release got %h %h %0d %h exp c %h 3 c", if_id_pc, if_id_instr, fetch_count, imem_addr, mem_word(32'h8)); end
   endtask

   task automatic test_branch();
      branch_taken = 1'b1; branch_addr = 32'h3E;
      step();
      branch_taken = 1'b0;
      tests++; if (imem_addr !== 32'h3C || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 || fetch_count !== 3)
         begin fails++; $display("FAIL br_flush got %h %b %h %h %0d exp 3c 0 0 0 3", imem_addr, if_id_valid, if_id_instr, if_id_pc, fetch_count); end
      step();
      tests++; if (if_id_instr !== mem_word(32'h3C) || if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || fetch_count !== 4)
         begin fails++; $display("FAIL br_target got %h %h %b %0d exp %h 40 1 4", if_id_instr, if_id_pc, if_id_valid, fetch_count, mem_word(32'h3C)); end
   endtask

   task automatic test_branch_freeze();
      branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h100;
      step();
      branch_taken = 1'b0; freeze = 1'b0;
      tests++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_count !== 4)
         begin fails++; $display("FAIL brfrz got %h %b %h %0d exp 100 0 0 4", imem_addr, if_id_valid, if_id_instr, fetch_count); end
      step();
      tests++; if (if_id_instr !== mem_word(32'h100) || if_id_pc !== 32'h104 || fetch_count !== 5)
         begin fails++; $display("FAIL brfrz_next got %h %h %0d exp %h 104 5", if_id_instr, if_id_pc, fetch_count, mem_word(32'h100)); end
   endtask

   task automatic test_wrap();
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
      step();
      branch_taken = 1'b0;
      tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_align got %h exp fffffffc", imem_addr); end
      step();
      tests++; if (if_id_pc !== 32'h0 || imem_addr !== 32'h0 || if_id_instr !== mem_word(32'hFFFF_FFFC) || fetch_count !== 6)
         begin fails++; $display("FAIL wrap_pc got %h %h %h %0d exp 0 0 %h 6", if_id_pc, imem_addr, if_id_instr, fetch_count, mem_word(32'hFFFF_FFFC)); end
      for (int i = 0; i < 57; i++) step();
      tests++; if (fetch_count !== 6'h3F) begin fails++; $display("FAIL cnt_max got %0d exp 63", fetch_count); end
      step();
      tests++; if (fetch_count !== 6'h0 || if_id_valid !== 1'b1) begin fails++; $display("FAIL cnt_wrap got %0d %b exp 0 1", fetch_count, if_id_valid); end
   endtask

   task automatic test_async_reset();
      freeze = 1'b1;
      #2 rst = 1'b1;
      #1;
      tests++; if (imem_addr !== 32'h0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 0)
         begin fails++; $display("FAIL async_rst got %h %h %h %b %0d exp all 0", imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count); end
      step();
      rst = 1'b0;
      step();
      tests++; if (if_id_valid !== 1'b0 || fetch_count !== 0) begin fails++; $display("FAIL boot_frz got %b %0d exp 0 0", if_id_valid, fetch_count); end
      do_reset();
      step();
      tests++; if (if_id_instr !== mem_word(32'h0) || if_id_pc !== 32'h4 || if_id_valid !== 1'b1 || fetch_count !== 1)
         begin fails++; $display("FAIL resume got %h %h %b %0d exp %h 4 1 1", if_id_instr, if_id_pc, if_id_valid, fetch_count, mem_word(32'h0)); end
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      test_reset();
      test_sequential();
      test_freeze();
      test_branch();
      test_branch_freeze();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
